// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake, redirect input and the
// output register presented to decode.
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic [5:0]        if_opcode;
  logic              halted;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode, halted,
    input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode, halted,
    output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// SimpleRisc instruction fetch: PC, single-outstanding imem request, one-entry
// output register to decode, redirect flush and hlt detection.
//
// state       | meaning
// ------------+-------------------------------------------------------
// S_FETCH     | nothing outstanding, may issue a request
// S_WAIT      | one request outstanding, response will be delivered
// S_WAIT_DROP | one request outstanding, response will be discarded
// S_HALT      | hlt delivered, no requests until redirect or reset
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_WAIT      = 2'd1,
    S_WAIT_DROP = 2'd2,
    S_HALT      = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              if_valid_q;
  logic [31:0]       if_instr_q;
  logic [ADDR_W-1:0] if_pc_q;

  logic outstanding;
  logic req;
  logic accept;
  logic deliver;
  logic is_hlt;

  assign accept  = req && bus.imem_ready;
  assign is_hlt  = (bus.imem_rdata[31:27] == 5'b11111);
  assign deliver = bus.imem_rvalid && (state_q == S_WAIT) && !bus.redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid) begin
      // A request still in flight at redirect time must have its response swallowed.
      state_d = (outstanding && !bus.imem_rvalid) ? S_WAIT_DROP : S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:     if (accept)          state_d = S_WAIT;
        S_WAIT:      if (bus.imem_rvalid) state_d = is_hlt ? S_HALT : S_FETCH;
        S_WAIT_DROP: if (bus.imem_rvalid) state_d = S_FETCH;
        S_HALT:                           state_d = S_HALT;
        default:                          state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    outstanding = (state_q == S_WAIT) || (state_q == S_WAIT_DROP);
    // rst_n term keeps the request low while reset is asserted.
    req = rst_n && (state_q == S_FETCH) && !bus.redirect_valid &&
          (!if_valid_q || bus.if_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      if (bus.redirect_valid) begin
        pc_q <= bus.redirect_pc & ~ADDR_W'(3);
      end else if (accept) begin
        pc_q <= pc_q + ADDR_W'(4);
      end

      if (accept) req_pc_q <= pc_q;

      if (bus.redirect_valid) begin
        if_valid_q <= 1'b0;
      end else if (deliver) begin
        if_valid_q <= 1'b1;
      end else if (bus.if_ready) begin
        if_valid_q <= 1'b0;
      end

      if (deliver) begin
        if_instr_q <= bus.imem_rdata;
        if_pc_q    <= req_pc_q;
      end
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_opcode = if_instr_q[31:26];
  assign bus.halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small imem driver, scoreboard of expected
// deliveries, and redirect / back-pressure / halt / reset scenarios.
module tb_fetch_unit;

  localparam int ADDR_W = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_entry_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;
  sb_entry_t sb[$];

  fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request at address a, answer it after lat cycles with word w.
  task automatic fetch(input logic [31:0] a, input logic [31:0] w, input int lat,
                       input logic rdy_after);
    sb_entry_t e;
    bus.imem_ready = 1'b1;
    #1;
    chk("req_high", 32'(bus.imem_req), 32'd1);
    chk("req_addr", bus.imem_addr, a);
    @(posedge clk);
    @(negedge clk);
    bus.imem_ready = 1'b0;
    #1;
    chk("req_busy", 32'(bus.imem_req), 32'd0);
    repeat (lat - 1) @(negedge clk);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = w;
    bus.if_ready    = rdy_after;
    e.pc = a;
    e.instr = w;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("if_valid", 32'(bus.if_valid), 32'd1);
      chk("if_pc", bus.if_pc, e.pc);
      chk("if_instr", bus.if_instr, e.instr);
      chk("if_opcode", 32'(bus.if_opcode), 32'(e.instr[31:26]));
      chk("halted", 32'(bus.halted), 32'(e.instr[31:27] == 5'b11111));
    end
  endtask

  task automatic redirect_to(input logic [31:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = t;
    #1;
    chk("redir_req_low", 32'(bus.imem_req), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    bus.imem_ready     = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b1;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_instr", bus.if_instr, 32'd0);
    chk("rst_pc", bus.if_pc, 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch, 1-cycle memory.
    fetch(32'h0, 32'h0000_0000, 1, 1'b1);
    chk("opc_add", 32'(bus.if_opcode), 32'h00);
    fetch(32'h4, 32'h0800_0000, 1, 1'b1);
    chk("opc_sub", 32'(bus.if_opcode), 32'h02);

    // Back-pressure on the instruction at 0x8.
    fetch(32'h8, 32'h1234_5678, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_pc", bus.if_pc, 32'h8);
      chk("bp_instr", bus.if_instr, 32'h1234_5678);
      chk("bp_req", 32'(bus.imem_req), 32'd0);
    end
    bus.if_ready = 1'b1;
    #1;
    chk("bp_release_addr", bus.imem_addr, 32'hC);
    fetch(32'hC, 32'h2000_0001, 1, 1'b1);

    // Redirect while a request to 0x10 is outstanding.
    bus.imem_ready = 1'b1;
    #1;
    chk("rd1_addr", bus.imem_addr, 32'h10);
    @(posedge clk);
    @(negedge clk);
    bus.imem_ready = 1'b0;
    redirect_to(32'h103);
    chk("rd1_flush", 32'(bus.if_valid), 32'd0);
    chk("rd1_wait_req", 32'(bus.imem_req), 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    #1;
    chk("rd1_dropped", 32'(bus.if_valid), 32'd0);
    chk("rd1_req", 32'(bus.imem_req), 32'd1);
    chk("rd1_target", bus.imem_addr, 32'h100);
    fetch(32'h100, 32'h3000_0002, 2, 1'b1);

    // Redirect coincident with the response for 0x104.
    bus.imem_ready = 1'b1;
    #1;
    chk("rd2_addr", bus.imem_addr, 32'h104);
    @(posedge clk);
    @(negedge clk);
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_BAD0;
    redirect_to(32'h200);
    bus.imem_rvalid = 1'b0;
    chk("rd2_dropped", 32'(bus.if_valid), 32'd0);
    chk("rd2_req_nodrop", 32'(bus.imem_req), 32'd1);
    chk("rd2_target", bus.imem_addr, 32'h200);
    fetch(32'h200, 32'h4000_0003, 1, 1'b1);

    // Halt at 0x20.
    redirect_to(32'h20);
    fetch(32'h20, 32'hF800_0000, 1, 1'b1);
    chk("hlt_opcode", 32'(bus.if_opcode), 32'h3E);
    chk("hlt_req", 32'(bus.imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("halt_req", 32'(bus.imem_req), 32'd0);
      chk("halt_flag", 32'(bus.halted), 32'd1);
    end
    chk("halt_consumed", 32'(bus.if_valid), 32'd0);
    redirect_to(32'h40);
    chk("unhalt", 32'(bus.halted), 32'd0);
    fetch(32'h40, 32'h0C00_0004, 1, 1'b1);

    // Reset mid-operation: instruction held at 0x44, then request 0x48 in flight.
    fetch(32'h44, 32'h1000_0005, 1, 1'b0);
    bus.if_ready   = 1'b1;
    bus.imem_ready = 1'b1;
    #1;
    chk("mid_addr", bus.imem_addr, 32'h48);
    @(posedge clk);
    @(negedge clk);
    bus.imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
    chk("mid_rst_valid", 32'(bus.if_valid), 32'd0);
    chk("mid_rst_pc", bus.if_pc, 32'd0);
    chk("mid_rst_instr", bus.if_instr, 32'd0);
    chk("mid_rst_halted", 32'(bus.halted), 32'd0);
    chk("mid_rst_addr", bus.imem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    #1;
    chk("stale_ignored", 32'(bus.if_valid), 32'd0);
    chk("stale_halted", 32'(bus.halted), 32'd0);
    fetch(32'h0, 32'h0400_0006, 1, 1'b1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the SimpleRisc pipeline, directly upstream of the opcode decoder/control unit.
- Maintains the PC and fetches 32-bit words from instruction memory over a req/ready + rvalid handshake.
- Holds one fetched instruction in an output register, presented with its PC and its 6-bit opcode field to decode.
- Handles downstream back-pressure, branch/call/ret redirects from later stages, and halt detection.

Parameters:
- ADDR_W, 32, PC and memory address width.
- RESET_PC, 0, PC loaded on reset; must be word aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address; equals pc_q while imem_req is high.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; arbitrary latency ≥1 cycle after acceptance.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  taken branch/call/ret from a later stage.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] forced to 0 internally.
- if_valid  out  1  output register holds an instruction.
- if_ready  in  1  decode/operand-fetch consumes this cycle.
- if_instr  out  32  instruction word.
- if_pc  out  ADDR_W  address of if_instr.
- if_opcode  out  6  if_instr[31:26] ({5-bit opcode, I-bit}), feeds the control unit directly.
- halted  out  1  fetch stopped on a hlt instruction.

Behaviour:
- Reset (async, rst_n low): pc_q = RESET_PC; if_valid = 0; if_instr = 0; if_pc = 0; halted = 0; imem_req = 0; outstanding = 0; drop = 0.
- At most one outstanding memory request.
- imem_req = !halted && !outstanding && !redirect_valid && (!if_valid || if_ready).
- Accept (imem_req && imem_ready):
  - outstanding = 1; req_pc = pc_q; pc_q += 4 (wraps modulo 2^ADDR_W).
- Response (imem_rvalid && outstanding):
  - outstanding = 0.
  - If drop = 1 or redirect_valid is high this cycle: discard the word; clear drop.
  - Otherwise: if_instr = imem_rdata; if_pc = req_pc; if_valid = 1.
  - If imem_rdata[31:27] == 5'b11111 (hlt): halted = 1. The hlt word is still delivered to decode.
- imem_rvalid while outstanding = 0: ignored (protocol error), no state change.
- Consume (if_valid && if_ready): if_valid clears unless a new response loads in the same cycle; the new response wins.
- Steady-state throughput with 1-cycle memory: one instruction per 2 cycles. Throughput above that is not required.
- Redirect (redirect_valid high), highest priority over everything except reset:
  - pc_q = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - if_valid = 0 (flush).
  - halted = 0, since a wrong-path hlt is cancelled.
  - If outstanding and no rvalid this cycle: drop = 1.
  - imem_req is 0 during this cycle; fetch from the target starts the next cycle.
- While halted:
  - No requests are issued.
  - An already-captured hlt stays in the output register until consumed.
  - Only a redirect or reset leaves the halted state.
- State summary:
  - FETCH: no outstanding request, may request.
  - WAIT: outstanding = 1.
  - WAIT_DROP: outstanding = 1, drop = 1.
  - HALT.
  - Output-register validity is tracked independently of these states.
- if_opcode is purely combinational from if_instr, so zero added latency into the control unit.
- if_instr, if_pc and if_opcode are stable while if_valid && !if_ready.

Test Plan:
- Reset then sequential fetch, memory ready=1 with 1-cycle latency, words 0x0000_0000 (add), 0x0800_0000 (sub) -> imem_addr 0x0, 0x4, ...; if_pc 0x0 then 0x4; if_opcode 6'b000000 then 6'b000010.
- Back-pressure: hold if_ready=0 for 5 cycles with an instruction at pc 0x8 -> if_instr/if_pc stable; imem_req stays 0; on release, next request goes to 0xC.
- Redirect while outstanding: request to 0x10 accepted, redirect_pc=0x103 on the next cycle, response arrives 2 cycles later -> response discarded, if_valid=0, next imem_addr=0x100.
- Redirect coincident with imem_rvalid -> word discarded, drop stays 0, next fetch at the target.
- Halt: fetch 0xF800_0000 at pc 0x20 -> delivered with if_opcode 6'b111110; halted=1; no further imem_req. A later redirect to 0x40 clears halted and fetch resumes at 0x40.
- Reset mid-operation: assert rst_n low while outstanding and if_valid=1 -> all outputs at reset values immediately. A stale imem_rvalid after reset release is ignored, and the first fetch goes to RESET_PC.
